// File: rtl/div_hilo_sequencer_pkg.sv
// Shared definitions for the HI/LO divide sequencer: state encoding, default width
// and the LO pattern committed on divide-by-zero.
package div_hilo_sequencer_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_LO = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_SETTLE = 2'd2,
    ST_COMMIT = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_hilo_sequencer_if.sv
// Request / HI-LO bus between the ALU op decode (master) and the divide sequencer (slave).
interface div_hilo_sequencer_if
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic             req_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_in;
  logic [WIDTH-1:0] lo_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output req_valid, req_signed, dividend, divisor, hi_we, lo_we, hi_in, lo_in,
    input  req_ready, hi_out, lo_out, busy, done, div_zero
  );

  modport slave (
    input  req_valid, req_signed, dividend, divisor, hi_we, lo_we, hi_in, lo_in,
    output req_ready, hi_out, lo_out, busy, done, div_zero
  );

endinterface

// File: rtl/div_hilo_sequencer_core.sv
// Combinational non-restoring unsigned divider; one long carry chain per quotient bit,
// so its outputs need several cycles to settle after the operands change.
module div_hilo_sequencer_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  // Partial remainder stays in [-2d, 2d), so two guard bits cover shift and sign.
  logic [WIDTH+1:0] rem;
  logic [WIDTH+1:0] dvs_ext;

  always_comb begin
    rem        = '0;
    quotient_o = '0;
    dvs_ext    = {2'b00, divisor_i};
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (rem[WIDTH+1]) rem = {rem[WIDTH:0], dividend_i[i]} + dvs_ext;
      else              rem = {rem[WIDTH:0], dividend_i[i]} - dvs_ext;
      quotient_o[i] = ~rem[WIDTH+1];
    end
    if (rem[WIDTH+1]) rem = rem + dvs_ext;
    remainder_o = rem[WIDTH-1:0];
  end

endmodule

// File: rtl/div_hilo_sequencer.sv
// Multi-cycle divide sequencer: conditions operands for the divider core, waits for it
// to settle, applies the signed fix-up and commits quotient->LO, remainder->HI.
//
//   state     | meaning
//   ST_IDLE   | ready; accepts requests and direct HI/LO writes
//   ST_LAUNCH | operand magnitudes loaded into core, settle counter loaded
//   ST_SETTLE | core outputs resolving; results captured when counter hits 0
//   ST_COMMIT | HI/LO hold the new result, done pulses
module div_hilo_sequencer
  import div_hilo_sequencer_pkg::*;
#(
  parameter int WIDTH         = DIV_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 clear,
  div_hilo_sequencer_if.slave  bus
);

  localparam int            CW       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] mag_dvd_q, mag_dvd_d;
  logic [WIDTH-1:0] mag_dvs_q, mag_dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             sgn_q, sgn_d;
  logic             zero_q, zero_d;
  logic             div_zero_q, div_zero_d;

  logic [WIDTH-1:0] q_core, r_core, q_fix, r_fix;
  logic             q_neg, r_neg;

  div_hilo_sequencer_core #(.WIDTH(WIDTH)) u_core (
    .dividend_i  (mag_dvd_q),
    .divisor_i   (mag_dvs_q),
    .quotient_o  (q_core),
    .remainder_o (r_core)
  );

  // Quotient sign from both operands, remainder sign follows the dividend.
  assign q_neg = sgn_q & (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
  assign r_neg = sgn_q & dvd_q[WIDTH-1];
  assign q_fix = q_neg ? -q_core : q_core;
  assign r_fix = r_neg ? -r_core : r_core;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    mag_dvd_d  = mag_dvd_q;
    mag_dvs_d  = mag_dvs_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    sgn_d      = sgn_q;
    zero_d     = zero_q;
    div_zero_d = div_zero_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.hi_we) hi_d = bus.hi_in;
        if (bus.lo_we) lo_d = bus.lo_in;
        if (bus.req_valid) begin
          dvd_d      = bus.dividend;
          dvs_d      = bus.divisor;
          sgn_d      = bus.req_signed;
          div_zero_d = 1'b0;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        // Divide-by-zero spends a single settle cycle instead of the full countdown.
        if (dvs_q == '0) begin
          zero_d = 1'b1;
          cnt_d  = '0;
        end else begin
          zero_d    = 1'b0;
          cnt_d     = CNT_LOAD;
          mag_dvd_d = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
          mag_dvs_d = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
        end
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          if (zero_q) begin
            lo_d       = DIV_ZERO_LO;
            hi_d       = dvd_q;
            div_zero_d = 1'b1;
          end else begin
            lo_d = q_fix;
            hi_d = r_fix;
          end
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      mag_dvd_q  <= '0;
      mag_dvs_q  <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sgn_q      <= 1'b0;
      zero_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      mag_dvd_q  <= mag_dvd_d;
      mag_dvs_q  <= mag_dvs_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      sgn_q      <= sgn_d;
      zero_q     <= zero_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_COMMIT);
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.div_zero  = div_zero_q;

endmodule

// File: tb/tb_div_hilo_sequencer.sv
// Directed bench for the HI/LO divide sequencer: vector table plus hand-written
// sequences for write-while-busy, back-to-back requests and mid-operation reset.
module tb_div_hilo_sequencer;
  import div_hilo_sequencer_pkg::*;

  localparam int W = 32;
  localparam int S = 2;

  logic clk   = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  div_hilo_sequencer_if #(.WIDTH(W)) bus ();

  div_hilo_sequencer #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clock (clk),
    .clear (clear),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic sgn, logic [31:0] a, logic [31:0] b,
                              logic [31:0] lo, logic [31:0] hi, logic dz, int lat);
    vec_t v;
    v.name = name; v.sgn = sgn; v.a = a; v.b = b;
    v.lo = lo; v.hi = hi; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus.hi_we      = 1'b0;
    bus.lo_we      = 1'b0;
    bus.hi_in      = '0;
    bus.lo_in      = '0;
  endtask

  // Counts cycles after the accept edge until done is seen (bounded).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_div(string name, input logic sgn, input logic [31:0] a, b, output int lat);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check({name, " busy_after_accept"}, 32'(bus.busy), 32'd1);
    check({name, " ready_low"}, 32'(bus.req_ready), 32'd0);
    check({name, " dz_cleared_on_accept"}, 32'(bus.div_zero), 32'd0);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [31:0] lo_prev;
    int done_seen;

    vecs.push_back(mk("u100/7",      1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, S+2));
    vecs.push_back(mk("s-100/7",     1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, S+2));
    vecs.push_back(mk("s100/-7",     1'b1, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, S+2));
    vecs.push_back(mk("s-100/-7",    1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0, S+2));
    vecs.push_back(mk("u1234/0",     1'b0, 32'h1234,     32'd0,        32'hFFFFFFFF, 32'h1234,     1'b1, 3));
    vecs.push_back(mk("u10/3",       1'b0, 32'd10,       32'd3,        32'd3,        32'd1,        1'b0, S+2));
    vecs.push_back(mk("s_ovf",       1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, S+2));
    vecs.push_back(mk("u_ovf_ops",   1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, S+2));
    vecs.push_back(mk("umax/1",      1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, S+2));
    vecs.push_back(mk("s-7/0",       1'b1, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 3));
    vecs.push_back(mk("u7/100",      1'b0, 32'd7,        32'd100,      32'd0,        32'd7,        1'b0, S+2));
    vecs.push_back(mk("smin/2",      1'b1, 32'h80000000, 32'd2,        32'hC0000000, 32'd0,        1'b0, S+2));
    vecs.push_back(mk("umax/10000h", 1'b0, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0, S+2));

    idle_inputs();
    clear = 1'b0;
    repeat (2) @(negedge clk);
    check("reset hi", bus.hi_out, 32'd0);
    check("reset lo", bus.lo_out, 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset div_zero", 32'(bus.div_zero), 32'd0);
    clear = 1'b1;
    @(negedge clk);
    check("ready after reset", 32'(bus.req_ready), 32'd1);

    foreach (vecs[i]) begin
      run_div(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, " lo"}, bus.lo_out, vecs[i].lo);
      check({vecs[i].name, " hi"}, bus.hi_out, vecs[i].hi);
      check({vecs[i].name, " div_zero"}, 32'(bus.div_zero), 32'(vecs[i].dz));
      @(negedge clk);
      check({vecs[i].name, " done_one_cycle"}, 32'(bus.done), 32'd0);
      check({vecs[i].name, " ready_after_done"}, 32'(bus.req_ready), 32'd1);
      check({vecs[i].name, " lo_held"}, bus.lo_out, vecs[i].lo);
    end

    // Direct writes while busy are dropped; in IDLE both strobes write together.
    lo_prev = bus.lo_out;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_signed = 1'b0;
    bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.lo_we = 1'b1; bus.lo_in = 32'hDEAD;
    bus.hi_we = 1'b1; bus.hi_in = 32'hBEEF;
    @(negedge clk);
    bus.lo_we = 1'b0; bus.hi_we = 1'b0;
    check("we_busy lo_unchanged", bus.lo_out, lo_prev);
    wait_done(lat);
    check("we_busy lo", bus.lo_out, 32'd14);
    check("we_busy hi", bus.hi_out, 32'd2);
    @(negedge clk);
    bus.lo_we = 1'b1; bus.lo_in = 32'hA5;
    bus.hi_we = 1'b1; bus.hi_in = 32'h5A;
    @(negedge clk);
    bus.lo_we = 1'b0; bus.hi_we = 1'b0;
    check("we_idle lo", bus.lo_out, 32'hA5);
    check("we_idle hi", bus.hi_out, 32'h5A);

    // req_valid held through done: next request accepted on the first IDLE cycle.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_signed = 1'b0;
    bus.dividend = 32'd20; bus.divisor = 32'd6;
    @(negedge clk);
    wait_done(lat);
    check("held lat", 32'(lat), 32'(S+2));
    check("held lo", bus.lo_out, 32'd3);
    check("held hi", bus.hi_out, 32'd2);
    @(negedge clk);
    check("held ready_idle", 32'(bus.req_ready), 32'd1);
    bus.dividend = 32'd21; bus.divisor = 32'd4;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("held reaccept busy", 32'(bus.busy), 32'd1);
    wait_done(lat);
    check("held2 lo", bus.lo_out, 32'd5);
    check("held2 hi", bus.hi_out, 32'd1);
    @(negedge clk);

    // Accept with same-cycle writes, then abort with clear during SETTLE.
    bus.req_valid = 1'b1; bus.req_signed = 1'b1;
    bus.dividend = 32'd50; bus.divisor = 32'd3;
    bus.hi_we = 1'b1; bus.hi_in = 32'h77;
    bus.lo_we = 1'b1; bus.lo_in = 32'h66;
    @(negedge clk);
    idle_inputs();
    check("accept_write hi", bus.hi_out, 32'h77);
    check("accept_write lo", bus.lo_out, 32'h66);
    @(negedge clk);
    check("abort in_settle busy", 32'(bus.busy), 32'd1);
    clear = 1'b0;
    @(negedge clk);
    check("abort hi", bus.hi_out, 32'd0);
    check("abort lo", bus.lo_out, 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    clear = 1'b1;
    done_seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done) done_seen++;
    end
    check("abort no_done", 32'(done_seen), 32'd0);
    check("abort ready", 32'(bus.req_ready), 32'd1);
    check("abort lo_stays", bus.lo_out, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
